// File: rtl/eth_mgmt_pkg.sv
// Shared types and constants for the HSSI/ETH management-bus arbiter.
package eth_mgmt_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned HOST_WR_BIT = 16;
  localparam int unsigned HOST_RD_BIT = 17;
  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEADC0DE;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
  } t_mgmt_req;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StDone
  } t_mgmt_state;

endpackage

// File: rtl/eth_mgmt_host_cap.sv
// Host command capture: strobe edge detection, one-deep pending slot and the sticky host error.
module eth_mgmt_host_cap
  import eth_mgmt_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       ctrl_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              in_flight_i,
  input  logic              free_i,
  input  logic              err_set_i,
  output logic              slot_full_o,
  output t_mgmt_req         slot_o,
  output logic              err_o
);

  logic      wr_prev_q, rd_prev_q;
  logic      wr_rise, rd_rise, accept;
  logic      slot_full_q, slot_full_d;
  logic      err_q, err_d;
  t_mgmt_req slot_q, slot_d;
  logic      unused_ctrl;

  assign unused_ctrl = ^ctrl_addr_i[31:18];

  always_comb begin
    wr_rise     = ctrl_addr_i[HOST_WR_BIT] & ~wr_prev_q;
    rd_rise     = ctrl_addr_i[HOST_RD_BIT] & ~rd_prev_q;
    // Exactly one strobe edge, and nothing already queued or on the bus.
    accept      = (wr_rise ^ rd_rise) & ~slot_full_q & ~in_flight_i;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    err_d       = err_q;
    if (free_i) begin
      slot_full_d = 1'b0;
    end
    if (accept) begin
      slot_d      = '{addr: ctrl_addr_i[ADDR_W-1:0], wdata: wr_data_i, wr: wr_rise};
      slot_full_d = 1'b1;
      err_d       = 1'b0;
    end else if (wr_rise || rd_rise) begin
      err_d = 1'b1;
    end
    if (err_set_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_prev_q   <= 1'b0;
      rd_prev_q   <= 1'b0;
      slot_full_q <= 1'b0;
      slot_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_prev_q   <= ctrl_addr_i[HOST_WR_BIT];
      rd_prev_q   <= ctrl_addr_i[HOST_RD_BIT];
      slot_full_q <= slot_full_d;
      slot_q      <= slot_d;
      err_q       <= err_d;
    end
  end

  assign slot_full_o = slot_full_q;
  assign slot_o      = slot_q;
  assign err_o       = err_q;

endmodule

// File: rtl/eth_mgmt_arb.sv
// Round-robin arbiter and single-outstanding sequencer for the management Avalon-MM master.
module eth_mgmt_arb
  import eth_mgmt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              pClkDiv4,
  input  logic              rst_n,
  input  logic [31:0]       host_ctrl_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_busy,
  output logic              host_err,
  input  logic              init_req,
  input  logic              init_wr,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  output logic              init_ack,
  output logic [DATA_W-1:0] init_rdata,
  output logic              init_err,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_read,
  output logic              av_write,
  output logic [DATA_W-1:0] av_writedata,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_readdatavalid,
  input  logic              av_waitrequest
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] TmoMax = CntW'(TIMEOUT_CYC);

  t_mgmt_state       state_q;
  t_mgmt_req         req_q, host_slot, grant_req;
  logic              grant_init_q, prio_init_q;
  logic              av_read_q, av_write_q;
  logic [CntW-1:0]   tmo_cnt_q;
  logic [DATA_W-1:0] rdata_q, host_rd_data_q;
  logic              err_q, init_ack_q;
  logic              host_full, host_in_flight, host_done, grant_init;
  logic              accepted, wr_done, rd_done, tmo_hit;

  assign host_in_flight = (state_q != StIdle) & ~grant_init_q;
  assign host_done      = (state_q == StDone) & ~grant_init_q;
  // prio_init_q names the requester that wins a tie.
  assign grant_init     = init_req & (~host_full | prio_init_q);

  always_comb begin
    grant_req = host_slot;
    if (grant_init) begin
      grant_req = '{addr: init_addr, wdata: init_wdata, wr: init_wr};
    end
  end

  assign accepted = (state_q == StIssue) & ~av_waitrequest;
  assign wr_done  = accepted & req_q.wr;
  assign rd_done  = av_readdatavalid & ((state_q == StWaitRd) | (accepted & ~req_q.wr));
  assign tmo_hit  = (tmo_cnt_q == TmoMax);

  eth_mgmt_host_cap u_host_cap (
    .clk_i       (pClkDiv4),
    .rst_ni      (rst_n),
    .ctrl_addr_i (host_ctrl_addr),
    .wr_data_i   (host_wr_data),
    .in_flight_i (host_in_flight),
    .free_i      (host_done),
    .err_set_i   (host_done & err_q),
    .slot_full_o (host_full),
    .slot_o      (host_slot),
    .err_o       (host_err)
  );

  always_ff @(posedge pClkDiv4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_q          <= '0;
      grant_init_q   <= 1'b0;
      prio_init_q    <= 1'b0;
      av_read_q      <= 1'b0;
      av_write_q     <= 1'b0;
      tmo_cnt_q      <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      init_ack_q     <= 1'b0;
      host_rd_data_q <= '0;
    end else begin
      init_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (init_req || host_full) begin
            grant_init_q <= grant_init;
            req_q        <= grant_req;
            av_write_q   <= grant_req.wr;
            av_read_q    <= ~grant_req.wr;
            tmo_cnt_q    <= '0;
            state_q      <= StIssue;
          end
        end
        StIssue, StWaitRd: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (accepted || tmo_hit) begin
            av_read_q  <= 1'b0;
            av_write_q <= 1'b0;
          end
          if (tmo_hit) begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
          end else if (wr_done || rd_done) begin
            rdata_q <= rd_done ? av_readdata : '0;
            err_q   <= 1'b0;
          end
          if (tmo_hit || wr_done || rd_done) begin
            init_ack_q <= grant_init_q;
            state_q    <= StDone;
          end else if (accepted) begin
            state_q <= StWaitRd;
          end
        end
        StDone: begin
          prio_init_q <= ~grant_init_q;
          if (!grant_init_q && !req_q.wr) begin
            host_rd_data_q <= rdata_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign host_rd_data = host_rd_data_q;
  assign host_busy    = host_full | host_in_flight;
  assign init_ack     = init_ack_q;
  assign init_rdata   = rdata_q;
  assign init_err     = err_q;
  assign av_address   = req_q.addr;
  assign av_writedata = req_q.wdata;
  assign av_read      = av_read_q;
  assign av_write     = av_write_q;

endmodule
